// File: rtl/frac_search_grid.sv
`default_nettype none
// ============================================================================
// Module   : frac_search_grid
// Purpose  : Fractional-pel MV search. Accumulates per-candidate SAD row by row,
//            then scans the candidates for the lowest cost (lowest index on tie).
// Options  : FRAC_SEARCH_MVCOST_EN adds MV_BIAS to every non-center cost.
// Revision : 1.0 - initial release
// ============================================================================
module frac_search_grid #(
  parameter  int PIX_W      = 8,
  parameter  int ROW_PIX    = 8,
  parameter  int ROWS       = 8,
  parameter  int NUM_CAND   = 9,
  parameter  int CENTER_IDX = 4,
  parameter  int MV_BIAS    = 16,
  localparam int IDX_W      = $clog2(NUM_CAND),
  localparam int SAD_W      = PIX_W + $clog2(ROW_PIX * ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [ROW_PIX*PIX_W-1:0]           ref_row,
  input  logic [NUM_CAND*ROW_PIX*PIX_W-1:0]  cand_rows,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [IDX_W-1:0]                   best_idx,
  output logic [SAD_W-1:0]                   best_sad
);

  localparam int             c_ROW_BITS = ROW_PIX * PIX_W;
  localparam int             c_ROW_W    = $clog2(ROWS + 1);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_CAND - 1);
  localparam logic [IDX_W-1:0]   c_CENTER   = IDX_W'(CENTER_IDX);
  localparam logic [SAD_W:0]     c_BIAS     = (SAD_W + 1)'(MV_BIAS);
`ifdef FRAC_SEARCH_MVCOST_EN
  localparam logic c_MVCOST_EN = 1'b1;
`else
  localparam logic c_MVCOST_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_accept;
  logic [SAD_W-1:0]     w_row_sad [NUM_CAND];
  logic [SAD_W-1:0]     r_acc     [NUM_CAND];
  logic [c_ROW_W-1:0]   r_row_cnt;
  logic [IDX_W-1:0]     r_scan_idx;
  logic [SAD_W:0]       r_best_cost;
  logic [SAD_W-1:0]     w_cand_sad;
  logic                 w_bias_on;
  logic [SAD_W:0]       w_cost;

  function automatic logic [SAD_W-1:0] row_sad(input logic [c_ROW_BITS-1:0] cand,
                                               input logic [c_ROW_BITS-1:0] refr);
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic [SAD_W-1:0] s;
    s = '0;
    for (int p = 0; p < ROW_PIX; p++) begin
      a = cand[p*PIX_W +: PIX_W];
      b = refr[p*PIX_W +: PIX_W];
      s = s + SAD_W'((a > b) ? (a - b) : (b - a));
    end
    return s;
  endfunction

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_row_sad
    assign w_row_sad[k] = row_sad(cand_rows[k*c_ROW_BITS +: c_ROW_BITS], ref_row);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) w_state_next = (ROWS == 1) ? S_SCAN : S_ACC;
      end
      S_ACC: begin
        in_ready = !reset;
        if (in_valid && !reset && r_row_cnt == c_LAST_ROW) w_state_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_scan_idx == c_LAST_IDX) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept   = in_valid && in_ready;
  assign w_cand_sad = r_acc[r_scan_idx];
  // Bias path folds to zero when the MV-cost option is not built in.
  assign w_bias_on  = c_MVCOST_EN && (r_scan_idx != c_CENTER);
  assign w_cost     = {1'b0, w_cand_sad} + (w_bias_on ? c_BIAS : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CAND; k++) r_acc[k] <= '0;
      r_row_cnt   <= '0;
      r_scan_idx  <= '0;
      r_best_cost <= '0;
      best_idx    <= '0;
      best_sad    <= '0;
    end else begin
      if (w_accept) begin
        r_scan_idx <= '0;
        if (r_state == S_IDLE) begin
          for (int k = 0; k < NUM_CAND; k++) r_acc[k] <= w_row_sad[k];
          r_row_cnt <= c_ROW_W'(1);
        end else begin
          for (int k = 0; k < NUM_CAND; k++) r_acc[k] <= r_acc[k] + w_row_sad[k];
          r_row_cnt <= r_row_cnt + 1'b1;
        end
      end
      if (r_state == S_SCAN) begin
        // Strict less-than keeps the lowest index on equal cost.
        if (r_scan_idx == '0 || w_cost < r_best_cost) begin
          r_best_cost <= w_cost;
          best_idx    <= r_scan_idx;
          best_sad    <= w_cand_sad;
        end
        if (r_scan_idx != c_LAST_IDX) r_scan_idx <= r_scan_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frac_search_grid.sv
`default_nettype none
// ============================================================================
// Module   : tb_frac_search_grid
// Purpose  : Directed self-checking bench for frac_search_grid (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frac_search_grid;

  localparam int RW = 64;
  localparam int CW = 9 * 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [RW-1:0] ref_row = '0;
  logic [CW-1:0] cand_rows = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    best_idx;
  logic [13:0]   best_sad;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  frac_search_grid dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ref_row   (ref_row),
    .cand_rows (cand_rows),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .best_idx  (best_idx),
    .best_sad  (best_sad)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [RW-1:0] mk_ref(int r);
    logic [RW-1:0] v;
    for (int p = 0; p < 8; p++) v[p*8 +: 8] = 8'((r * 16 + p * 3) & 127);
    return v;
  endfunction

  // Candidate win equals the reference; all others are ref+off per pixel.
  function automatic logic [CW-1:0] mk_cands(logic [RW-1:0] r, int win, int off);
    logic [CW-1:0] c;
    for (int k = 0; k < 9; k++)
      for (int p = 0; p < 8; p++)
        c[(k*8+p)*8 +: 8] = r[p*8 +: 8] + ((k == win) ? 8'd0 : 8'(off));
    return c;
  endfunction

  task automatic send_row(input logic [RW-1:0] r, input logic [CW-1:0] c,
                          input int gap, output int acc_cyc);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_valid  = 1'b1;
    ref_row   = r;
    cand_rows = c;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL row_accept: in_ready=%0d after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_out(output int out_cyc);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_cyc = cyc;
    n_vec++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL out_valid_timeout: out_valid=%0d, required 1", out_valid);
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL rst_in_ready: got %0d required 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL rst_out_valid: got %0d required 0", out_valid); end
    n_vec++; if (best_idx !== 4'd0)   begin n_err++; $display("FAIL rst_best_idx: got %0d required 0", best_idx); end
    n_vec++; if (best_sad !== 14'd0)  begin n_err++; $display("FAIL rst_best_sad: got %0d required 0", best_sad); end
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL idle_in_ready: got %0d required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int e, t;
    for (int r = 0; r < 8; r++) send_row(mk_ref(r), mk_cands(mk_ref(r), 4, 1), 0, e);
    wait_out(t);
    n_vec++; if (t - e !== 9)         begin n_err++; $display("FAIL b2b_latency: got %0d required 9", t - e); end
    n_vec++; if (best_idx !== 4'd4)   begin n_err++; $display("FAIL b2b_best_idx: got %0d required 4", best_idx); end
    n_vec++; if (best_sad !== 14'd0)  begin n_err++; $display("FAIL b2b_best_sad: got %0d required 0", best_sad); end
    n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL done_in_ready: got %0d required 0", in_ready); end
    take_result();
    n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL handshake_out_valid: got %0d required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL handshake_in_ready: got %0d required 1", in_ready); end
  endtask

  task automatic test_tie();
    int e, t;
    for (int r = 0; r < 8; r++) send_row(mk_ref(r + 1), mk_cands(mk_ref(r + 1), -1, 0), 0, e);
    wait_out(t);
    n_vec++; if (best_idx !== 4'd0)   begin n_err++; $display("FAIL tie_best_idx: got %0d required 0", best_idx); end
    n_vec++; if (best_sad !== 14'd0)  begin n_err++; $display("FAIL tie_best_sad: got %0d required 0", best_sad); end
    take_result();
  endtask

  task automatic test_worst();
    int e, t;
    logic [CW-1:0] c;
    for (int k = 0; k < 9; k++)
      for (int p = 0; p < 8; p++) c[(k*8+p)*8 +: 8] = (k == 8) ? 8'd254 : 8'd255;
    for (int r = 0; r < 8; r++) send_row('0, c, 0, e);
    wait_out(t);
    n_vec++; if (best_idx !== 4'd8)      begin n_err++; $display("FAIL worst_best_idx: got %0d required 8", best_idx); end
    n_vec++; if (best_sad !== 14'd16256) begin n_err++; $display("FAIL worst_best_sad: got %0d required 16256", best_sad); end
    take_result();
  endtask

  task automatic test_gaps_stall();
    int e, t;
    for (int r = 0; r < 8; r++)
      send_row(mk_ref(r + 2), mk_cands(mk_ref(r + 2), 7, 3), int'($urandom_range(0, 3)), e);
    wait_out(t);
    // Offer a beat while the result is pending; it must be ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      ref_row   = mk_ref(5);
      cand_rows = mk_cands(mk_ref(5), 0, 9);
      #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %0d required 1", i, out_valid); end
      n_vec++; if (in_ready !== 1'b0)  begin n_err++; $display("FAIL stall_in_ready[%0d]: got %0d required 0", i, in_ready); end
      n_vec++; if (best_idx !== 4'd7)  begin n_err++; $display("FAIL stall_best_idx[%0d]: got %0d required 7", i, best_idx); end
      n_vec++; if (best_sad !== 14'd0) begin n_err++; $display("FAIL stall_best_sad[%0d]: got %0d required 0", i, best_sad); end
    end
    in_valid = 1'b0;
    take_result();
    for (int r = 0; r < 8; r++) send_row(mk_ref(r), mk_cands(mk_ref(r), 2, 2), 0, e);
    wait_out(t);
    n_vec++; if (best_idx !== 4'd2)   begin n_err++; $display("FAIL next_best_idx: got %0d required 2", best_idx); end
    n_vec++; if (best_sad !== 14'd0)  begin n_err++; $display("FAIL next_best_sad: got %0d required 0", best_sad); end
    take_result();
  endtask

  task automatic test_reset_mid();
    int e, t;
    for (int r = 0; r < 3; r++) send_row(mk_ref(r), mk_cands(mk_ref(r), 1, 3), 0, e);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL mid_rst_in_ready: got %0d required 0", in_ready); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0)  begin n_err++; $display("FAIL post_rst_out_valid: got %0d required 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL post_rst_in_ready: got %0d required 1", in_ready); end
    for (int r = 0; r < 8; r++) send_row(mk_ref(r + 3), mk_cands(mk_ref(r + 3), 6, 1), 0, e);
    wait_out(t);
    n_vec++; if (t - e !== 9)         begin n_err++; $display("FAIL post_rst_latency: got %0d required 9", t - e); end
    n_vec++; if (best_idx !== 4'd6)   begin n_err++; $display("FAIL post_rst_best_idx: got %0d required 6", best_idx); end
    n_vec++; if (best_sad !== 14'd0)  begin n_err++; $display("FAIL post_rst_best_sad: got %0d required 0", best_sad); end
    take_result();
  endtask

  task automatic test_mvcost();
    int e, t;
    logic [CW-1:0] c;
    logic [3:0]    x_idx;
    logic [13:0]   x_sad;
`ifdef FRAC_SEARCH_MVCOST_EN
    x_idx = 4'd4; x_sad = 14'd10;
`else
    x_idx = 4'd0; x_sad = 14'd0;
`endif
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 9; k++)
        for (int p = 0; p < 8; p++)
          c[(k*8+p)*8 +: 8] = (k == 0) ? 8'd0 :
                              (k == 4) ? ((r == 0 && p == 0) ? 8'd10 : 8'd0) : 8'd2;
      send_row('0, c, 0, e);
    end
    wait_out(t);
    n_vec++; if (best_idx !== x_idx)  begin n_err++; $display("FAIL mv_best_idx: got %0d required %0d", best_idx, x_idx); end
    n_vec++; if (best_sad !== x_sad)  begin n_err++; $display("FAIL mv_best_sad: got %0d required %0d", best_sad, x_sad); end
    take_result();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_tie();
    test_worst();
    test_gaps_stall();
    test_reset_mid();
    test_mvcost();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
